// File: rtl/alu_pkg.sv
// Shared ALU/multdiv definitions: controller states, Booth step codes, datapath width.
package alu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of {L[0], q}.
  function automatic booth_op_t booth_decode(input logic [1:0] bits);
    case (bits)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step_ctl.sv
// Combinational Booth step: drives the shared adder and selects the 33-bit step result.
module booth_step_ctl
  import alu_pkg::*;
#(
  parameter int unsigned W = WORD_W
) (
  input  logic         active_i,
  input  logic [1:0]   bits_i,
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] m_i,
  input  logic [W-1:0] sum_i,
  input  logic         cout_i,
  output logic [W-1:0] add_a_o,
  output logic [W-1:0] add_b_o,
  output logic         add_cin_o,
  output logic [W:0]   s_o
);

  booth_op_t op;

  always_comb begin
    op        = active_i ? booth_decode(bits_i) : BOOTH_NOP;
    add_a_o   = u_i;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    s_o       = {u_i[W-1], u_i};
    // Bit 32 of the true sum is recovered from the operand signs and the adder carry-out.
    case (op)
      BOOTH_ADD: begin
        add_b_o = m_i;
        s_o     = {u_i[W-1] ^ m_i[W-1] ^ cout_i, sum_i};
      end
      BOOTH_SUB: begin
        add_b_o   = ~m_i;
        add_cin_o = 1'b1;
        s_o       = {u_i[W-1] ^ ~m_i[W-1] ^ cout_i, sum_i};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier using an external shared 32-bit adder; 33-cycle latency.
module booth_mult_seq
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS = WORD_W,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS-1:0] multiplicand,
  input  logic [N_BITS-1:0] multiplier,
  output logic [N_BITS-1:0] result,
  output logic              exception,
  output logic              ready,
  output logic              busy,
  output logic [N_BITS-1:0] add_a,
  output logic [N_BITS-1:0] add_b,
  output logic              add_cin,
  input  logic [N_BITS-1:0] add_sum,
  input  logic              add_cout
);

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   u_q, u_d;
  logic [N_BITS-1:0]   l_q, l_d;
  logic                q_q, q_d;
  logic [N_BITS-1:0]   m_q, m_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BITS-1:0]   result_q, result_d;
  logic                exc_q, exc_d;

  logic [N_BITS:0]     s;
  logic [N_BITS-1:0]   step_u, step_l;
  logic [N_BITS:0]     ovf_bits;

  booth_step_ctl #(.W(N_BITS)) u_step (
    .active_i (state_q == ST_RUN),
    .bits_i   ({l_q[0], q_q}),
    .u_i      (u_q),
    .m_i      (m_q),
    .sum_i    (add_sum),
    .cout_i   (add_cout),
    .add_a_o  (add_a),
    .add_b_o  (add_b),
    .add_cin_o(add_cin),
    .s_o      (s)
  );

  assign step_u   = s[N_BITS:1];
  assign step_l   = {s[0], l_q[N_BITS-1:1]};
  assign ovf_bits = {step_u, step_l[N_BITS-1]};

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    l_d      = l_q;
    q_d      = q_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      ST_RUN: begin
        u_d   = step_u;
        l_d   = step_l;
        q_d   = l_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_BITS - 1)) begin
          state_d  = ST_DONE;
          result_d = step_l;
          exc_d    = !((ovf_bits == '0) || (ovf_bits == '1));
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          m_d     = multiplicand;
          u_d     = '0;
          l_d     = multiplier;
          q_d     = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      u_q      <= '0;
      l_q      <= '0;
      q_q      <= 1'b0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      l_q      <= l_d;
      q_q      <= q_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign result    = result_q;
  assign exception = exc_q;
  assign ready     = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: product model from plain 64-bit arithmetic plus directed literals.
module tb_booth_mult_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [31:0] result;
  logic        exception;
  logic        ready;
  logic        busy;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  booth_mult_seq #(.N_BITS(32), .CNT_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .result      (result),
    .exception   (exception),
    .ready       (ready),
    .busy        (busy),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout)
  );

  function automatic logic [32:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint p;
    longint lim;
    logic [63:0] pb;
    lim = 64'sd2147483647;
    p   = longint'($signed(m)) * longint'($signed(q));
    pb  = p;
    return {(p > lim) || (p < -lim - 1), pb[31:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: k=0 idle, 1..32 running, 33 completion cycle.
  int          m_k;
  logic [31:0] m_res, m_pres;
  logic        m_exc, m_pexc;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_k   <= 0;
      m_res <= '0;
      m_exc <= 1'b0;
    end else if (m_k == 0 || m_k == 33) begin
      if (start) begin
        m_k <= 1;
        {m_pexc, m_pres} <= ref_mul(multiplicand, multiplier);
      end else begin
        m_k <= 0;
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k == 32) begin
        m_res <= m_pres;
        m_exc <= m_pexc;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_k >= 1 && m_k <= 32));
      chk("ready", 32'(ready), 32'(m_k == 33));
      chk("result", result, m_res);
      chk("exception", 32'(exception), 32'(m_exc));
      if (!(m_k >= 1 && m_k <= 32)) begin
        chk("idle_add_b", add_b, 32'h0);
        chk("idle_add_cin", 32'(add_cin), 32'h0);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic start_op(input logic [31:0] m, input logic [31:0] q);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(negedge clock);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_ready(input logic [31:0] exp_r, input logic exp_e, input string name,
                            input bit inject);
    int c  = 1;
    int nb = 0;
    bit found = 1'b0;
    while (c <= 40) begin
      if (ready) begin
        found = 1'b1;
        break;
      end
      if (busy) nb++;
      if (inject && c == 10) begin
        start        = 1'b1;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      if (inject && c == 11) start = 1'b0;
      @(negedge clock);
      c++;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no ready within 40 cycles, expected ready at cycle 33", name);
    end else begin
      chk({name, "_latency"}, 32'(c), 32'd33);
      chk({name, "_busy_cycles"}, 32'(nb), 32'd32);
      chk({name, "_result"}, result, exp_r);
      chk({name, "_exception"}, 32'(exception), 32'(exp_e));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [31:0] corners [8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,
                               32'h7FFF_FFFF, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_B505};

  initial begin
    logic [31:0] rm, rq;
    logic [32:0] e;
    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_exception", 32'(exception), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    idle(2);
    #2 reset = 1'b0;
    @(negedge clock);

    start_op(32'd3, 32'd5);
    wait_ready(32'd15, 1'b0, "basic", 1'b0);
    idle(2);
    start_op(32'hFFFF_FFF9, 32'd6);
    wait_ready(32'hFFFF_FFD6, 1'b0, "neg_m", 1'b0);
    idle(1);
    start_op(32'd6, 32'hFFFF_FFF9);
    wait_ready(32'hFFFF_FFD6, 1'b0, "neg_q", 1'b0);
    idle(1);
    start_op(32'd65536, 32'd65536);
    wait_ready(32'h0, 1'b1, "ovf_pos", 1'b0);
    idle(1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(32'h8000_0000, 1'b1, "ovf_min", 1'b0);
    idle(1);
    start_op(32'h8000_0000, 32'd1);
    wait_ready(32'h8000_0000, 1'b0, "min_x1", 1'b0);
    idle(1);
    start_op(32'd12, 32'hFFFF_FFF5);
    wait_ready(32'hFFFF_FF7C, 1'b0, "ignore_start", 1'b1);
    idle(1);

    start_op(32'd100, 32'd7);
    wait_ready(32'd700, 1'b0, "b2b_first", 1'b0);
    start_op(32'd1000, 32'hFFFF_FFFD);
    chk("b2b_hold_result", result, 32'd700);
    wait_ready(32'hFFFF_F448, 1'b0, "b2b_second", 1'b0);
    idle(2);

    start_op(32'd123, 32'd456);
    idle(14);
    #2 reset = 1'b1;
    #1;
    chk("abort_result", result, 32'h0);
    chk("abort_exception", 32'(exception), 32'h0);
    chk("abort_ready", 32'(ready), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    idle(2);
    #2 reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      chk("abort_no_ready", 32'(ready), 32'h0);
    end
    start_op(32'd2, 32'hFFFF_FFFD);
    wait_ready(32'hFFFF_FFFA, 1'b0, "post_reset", 1'b0);
    idle(1);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin rm = corners[$urandom_range(0, 7)]; rq = corners[$urandom_range(0, 7)]; end
        1: begin rm = 32'($signed($urandom_range(0, 65535)) - 32768);
                 rq = 32'($signed($urandom_range(0, 65535)) - 32768); end
        default: begin rm = $urandom; rq = $urandom; end
      endcase
      e = ref_mul(rm, rq);
      start_op(rm, rq);
      wait_ready(e[31:0], e[32], "rand", 1'b0);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
